// File: rtl/axi_lite_mem_s.sv
// AXI4-Lite slave with an integrated word-addressed RAM; read and write channels run independently.
// Optional range checking with SLVERR responses is enabled by defining AXI_LITE_MEM_S_SLVERR_EN.
module axi_lite_mem_s #(
   parameter int unsigned       DATA_W    = 32,
   parameter int unsigned       ADDR_W    = 32,
   parameter int unsigned       DEPTH     = 256,
   parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                axi_awvalid_i,
   output logic                axi_awready_o,
   input  logic [ADDR_W-1:0]   axi_awaddr_i,
   input  logic                axi_wvalid_i,
   output logic                axi_wready_o,
   input  logic [DATA_W-1:0]   axi_wdata_i,
   input  logic [DATA_W/8-1:0] axi_wstrb_i,
   output logic                axi_bvalid_o,
   input  logic                axi_bready_i,
   output logic [1:0]          axi_bresp_o,
   input  logic                axi_arvalid_i,
   output logic                axi_arready_o,
   input  logic [ADDR_W-1:0]   axi_araddr_i,
   output logic                axi_rvalid_o,
   input  logic                axi_rready_i,
   output logic [DATA_W-1:0]   axi_rdata_o,
   output logic [1:0]          axi_rresp_o
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned OB     = $clog2(STRB_W);
   localparam int unsigned IW     = $clog2(DEPTH);

   localparam logic [0:0] W_IDLE  = 1'b0;
   localparam logic [0:0] W_RESP  = 1'b1;
   localparam logic [0:0] R_IDLE  = 1'b0;
   localparam logic [0:0] R_VALID = 1'b1;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic [DATA_W-1:0] mem_r [DEPTH];

   logic [0:0]        w_state_r;
   logic              aw_done_r;
   logic              w_done_r;
   logic              awready_r;
   logic              wready_r;
   logic              bvalid_r;
   logic [1:0]        bresp_r;
   logic [ADDR_W-1:0] awaddr_r;
   logic [DATA_W-1:0] wdata_r;
   logic [STRB_W-1:0] wstrb_r;

   logic [0:0]        r_state_r;
   logic              arready_r;
   logic              rvalid_r;
   logic [1:0]        rresp_r;
   logic [DATA_W-1:0] rdata_r;

   logic              aw_hs_s;
   logic              w_hs_s;
   logic              ar_hs_s;
   logic              commit_s;
   logic [ADDR_W-1:0] waddr_s;
   logic [DATA_W-1:0] wdata_s;
   logic [STRB_W-1:0] wstrb_s;
   logic [IW-1:0]     widx_s;
   logic [IW-1:0]     ridx_s;
   logic              wok_s;
   logic              rok_s;

   function automatic logic [IW-1:0] word_idx(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off = addr - BASE_ADDR;
      return off[OB +: IW];
   endfunction

`ifdef AXI_LITE_MEM_S_SLVERR_EN
   localparam logic [ADDR_W:0] SPAN = (ADDR_W+1)'(DEPTH * STRB_W);

   function automatic logic addr_ok(input logic [ADDR_W-1:0] addr);
      logic [ADDR_W-1:0] off;
      off = addr - BASE_ADDR;
      return (addr >= BASE_ADDR) && ({1'b0, off} < SPAN);
   endfunction
`endif

   // Handshake decode; a beat arriving this cycle is forwarded so the commit needs no extra cycle
   always_comb begin
      aw_hs_s  = axi_awvalid_i & awready_r;
      w_hs_s   = axi_wvalid_i & wready_r;
      ar_hs_s  = axi_arvalid_i & arready_r;
      waddr_s  = aw_hs_s ? axi_awaddr_i : awaddr_r;
      wdata_s  = w_hs_s ? axi_wdata_i : wdata_r;
      wstrb_s  = w_hs_s ? axi_wstrb_i : wstrb_r;
      commit_s = (w_state_r == W_IDLE) & (aw_hs_s | aw_done_r) & (w_hs_s | w_done_r);
      widx_s   = word_idx(waddr_s);
      ridx_s   = word_idx(axi_araddr_i);
`ifdef AXI_LITE_MEM_S_SLVERR_EN
      wok_s    = addr_ok(waddr_s);
      rok_s    = addr_ok(axi_araddr_i);
`else
      wok_s    = 1'b1;
      rok_s    = 1'b1;
`endif
   end

   // Write channel FSM: collect AW and W in any order, then hold the B response
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         w_state_r <= W_IDLE;
         aw_done_r <= 1'b0;
         w_done_r  <= 1'b0;
         awready_r <= 1'b0;
         wready_r  <= 1'b0;
         bvalid_r  <= 1'b0;
         bresp_r   <= RESP_OKAY;
         awaddr_r  <= {ADDR_W{1'b0}};
         wdata_r   <= {DATA_W{1'b0}};
         wstrb_r   <= {STRB_W{1'b0}};
      end else begin
         case (w_state_r)
            W_IDLE: begin
               if (commit_s) begin
                  w_state_r <= W_RESP;
                  aw_done_r <= 1'b0;
                  w_done_r  <= 1'b0;
                  awready_r <= 1'b0;
                  wready_r  <= 1'b0;
                  bvalid_r  <= 1'b1;
                  bresp_r   <= wok_s ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  aw_done_r <= aw_done_r | aw_hs_s;
                  w_done_r  <= w_done_r | w_hs_s;
                  awready_r <= ~(aw_done_r | aw_hs_s);
                  wready_r  <= ~(w_done_r | w_hs_s);
                  if (aw_hs_s) begin
                     awaddr_r <= axi_awaddr_i;
                  end
                  if (w_hs_s) begin
                     wdata_r <= axi_wdata_i;
                     wstrb_r <= axi_wstrb_i;
                  end
               end
            end
            W_RESP: begin
               if (axi_bready_i) begin
                  w_state_r <= W_IDLE;
                  bvalid_r  <= 1'b0;
                  bresp_r   <= RESP_OKAY;
               end
            end
            default: begin
               w_state_r <= W_IDLE;
               aw_done_r <= 1'b0;
               w_done_r  <= 1'b0;
               awready_r <= 1'b0;
               wready_r  <= 1'b0;
               bvalid_r  <= 1'b0;
               bresp_r   <= RESP_OKAY;
            end
         endcase
      end
   end

   // Byte-masked array write; contents are deliberately not reset
   always_ff @(posedge clk_i) begin
      if (commit_s && wok_s) begin
         for (int k = 0; k < STRB_W; k++) begin
            if (wstrb_s[k]) begin
               mem_r[widx_s][8*k +: 8] <= wdata_s[8*k +: 8];
            end
         end
      end
   end

   // Read channel FSM; the array sample sees pre-write contents on a same-edge collision
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         r_state_r <= R_IDLE;
         arready_r <= 1'b0;
         rvalid_r  <= 1'b0;
         rresp_r   <= RESP_OKAY;
         rdata_r   <= {DATA_W{1'b0}};
      end else begin
         case (r_state_r)
            R_IDLE: begin
               if (ar_hs_s) begin
                  r_state_r <= R_VALID;
                  arready_r <= 1'b0;
                  rvalid_r  <= 1'b1;
                  rdata_r   <= rok_s ? mem_r[ridx_s] : {DATA_W{1'b0}};
                  rresp_r   <= rok_s ? RESP_OKAY : RESP_SLVERR;
               end else begin
                  arready_r <= 1'b1;
               end
            end
            R_VALID: begin
               if (axi_rready_i) begin
                  r_state_r <= R_IDLE;
                  arready_r <= 1'b1;
                  rvalid_r  <= 1'b0;
               end
            end
            default: begin
               r_state_r <= R_IDLE;
               arready_r <= 1'b0;
               rvalid_r  <= 1'b0;
               rresp_r   <= RESP_OKAY;
            end
         endcase
      end
   end

   assign axi_awready_o = awready_r;
   assign axi_wready_o  = wready_r;
   assign axi_bvalid_o  = bvalid_r;
   assign axi_bresp_o   = bresp_r;
   assign axi_arready_o = arready_r;
   assign axi_rvalid_o  = rvalid_r;
   assign axi_rdata_o   = rdata_r;
   assign axi_rresp_o   = rresp_r;

endmodule

// File: tb/tb_axi_lite_mem_s.sv
// Self-checking bench for axi_lite_mem_s: directed scenarios plus randomized traffic scored
// against a word/byte-level memory model. Honours AXI_LITE_MEM_S_SLVERR_EN when defined.
module tb_axi_lite_mem_s;
   localparam int          DATA_W = 32;
   localparam int          ADDR_W = 32;
   localparam int          DEPTH  = 256;
   localparam logic [31:0] BASE   = 32'h0000_4000;

   logic        clk;
   logic        rst_i;
   logic        axi_awvalid_i, axi_awready_o;
   logic [31:0] axi_awaddr_i;
   logic        axi_wvalid_i, axi_wready_o;
   logic [31:0] axi_wdata_i;
   logic [3:0]  axi_wstrb_i;
   logic        axi_bvalid_o, axi_bready_i;
   logic [1:0]  axi_bresp_o;
   logic        axi_arvalid_i, axi_arready_o;
   logic [31:0] axi_araddr_i;
   logic        axi_rvalid_o, axi_rready_i;
   logic [31:0] axi_rdata_o;
   logic [1:0]  axi_rresp_o;

   axi_lite_mem_s #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
      .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o), .axi_wdata_i(axi_wdata_i),
      .axi_wstrb_i(axi_wstrb_i), .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i),
      .axi_bresp_o(axi_bresp_o), .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o),
      .axi_araddr_i(axi_araddr_i), .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i),
      .axi_rdata_o(axi_rdata_o), .axi_rresp_o(axi_rresp_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   typedef struct {
      logic [31:0] data;
      logic [31:0] mask;
      logic [1:0]  resp;
   } r_exp_t;

   logic [31:0] mdl       [DEPTH];
   logic [3:0]  mdl_known [DEPTH];
   logic [1:0]  exp_b [$];
   r_exp_t      exp_r [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit in_range(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (a >= BASE) && (off < 32'd1024);
   endfunction

   function automatic int idx_of(input logic [31:0] a);
      logic [31:0] off;
      off = (a - BASE) >> 2;
      return int'(off % 32'd256);
   endfunction

   function automatic bit is_slverr(input logic [31:0] a);
`ifdef AXI_LITE_MEM_S_SLVERR_EN
      return !in_range(a);
`else
      return 1'b0;
`endif
   endfunction

   task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int i;
      if (is_slverr(a)) begin
         exp_b.push_back(2'b10);
      end else begin
         i = idx_of(a);
         for (int k = 0; k < 4; k++) begin
            if (s[k]) begin
               mdl[i][8*k +: 8] = d[8*k +: 8];
               mdl_known[i][k] = 1'b1;
            end
         end
         exp_b.push_back(2'b00);
      end
   endtask

   task automatic model_read(input logic [31:0] a);
      r_exp_t e;
      int     i;
      if (is_slverr(a)) begin
         e.data = 32'h0;
         e.mask = 32'hFFFF_FFFF;
         e.resp = 2'b10;
      end else begin
         i = idx_of(a);
         e.data = mdl[i];
         for (int k = 0; k < 4; k++) e.mask[8*k +: 8] = mdl_known[i][k] ? 8'hFF : 8'h00;
         e.resp = 2'b00;
      end
      exp_r.push_back(e);
   endtask

   // Compare process: every cycle, score valid responses and hold-stability against the model
   logic        prev_bstall, prev_rstall;
   logic [1:0]  prev_bresp, prev_rresp;
   logic [31:0] prev_rdata;
   always @(negedge clk) begin
      if (!rst_i) begin
         chk("reset_outputs", {axi_awready_o, axi_wready_o, axi_arready_o, axi_bvalid_o,
             axi_rvalid_o, axi_bresp_o, axi_rresp_o, axi_rdata_o}, 64'h0);
         exp_b.delete();
         exp_r.delete();
         prev_bstall = 1'b0;
         prev_rstall = 1'b0;
      end else begin
         if (prev_bstall) chk("b_stable", {axi_bvalid_o, axi_bresp_o}, {1'b1, prev_bresp});
         if (prev_rstall) chk("r_stable", {axi_rvalid_o, axi_rresp_o, axi_rdata_o},
                              {1'b1, prev_rresp, prev_rdata});
         if (axi_bvalid_o) begin
            chk("b_expected", exp_b.size() > 0, 1);
            chk("b_no_readies", {axi_awready_o, axi_wready_o}, 2'b00);
            if (exp_b.size() > 0) begin
               chk("bresp", axi_bresp_o, exp_b[0]);
               if (axi_bready_i) void'(exp_b.pop_front());
            end
         end
         if (axi_rvalid_o) begin
            chk("r_expected", exp_r.size() > 0, 1);
            chk("r_no_arready", axi_arready_o, 0);
            if (exp_r.size() > 0) begin
               chk("rresp", axi_rresp_o, exp_r[0].resp);
               chk("rdata", axi_rdata_o & exp_r[0].mask, exp_r[0].data & exp_r[0].mask);
               if (axi_rready_i) void'(exp_r.pop_front());
            end
         end
         prev_bstall = axi_bvalid_o && !axi_bready_i;
         prev_rstall = axi_rvalid_o && !axi_rready_i;
         prev_bresp  = axi_bresp_o;
         prev_rresp  = axi_rresp_o;
         prev_rdata  = axi_rdata_o;
      end
   end

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int aw_dly, input int w_dly, input int b_dly, input bit rst_mid,
                           output logic [1:0] resp);
      bit aw_pend = 1'b1;
      bit w_pend  = 1'b1;
      bit done    = 1'b0;
      int cyc     = 0;
      resp = 2'bxx;
      axi_awaddr_i = a;
      axi_wdata_i  = d;
      axi_wstrb_i  = s;
      while ((aw_pend || w_pend) && cyc < 40) begin
         axi_awvalid_i = aw_pend && (cyc >= aw_dly);
         axi_wvalid_i  = w_pend && (cyc >= w_dly);
         @(negedge clk);
         if (axi_awvalid_i && axi_awready_o) aw_pend = 1'b0;
         if (axi_wvalid_i && axi_wready_o) w_pend = 1'b0;
         if (!aw_pend && !w_pend) model_write(a, d, s);
         @(posedge clk); #1;
         cyc++;
      end
      axi_awvalid_i = 1'b0;
      axi_wvalid_i  = 1'b0;
      chk("aw_w_handshake", {aw_pend, w_pend}, 2'b00);
      if (aw_pend || w_pend) return;
      for (int c = 0; c < 40; c++) begin
         axi_bready_i = (c >= b_dly);
         @(negedge clk);
         if (c == 0) chk("b_latency", axi_bvalid_o, 1);
         if (rst_mid && c == 2) begin
            #2 rst_i = 1'b0;
            #1 chk("rst_drops_bvalid", axi_bvalid_o, 0);
            axi_bready_i = 1'b0;
            return;
         end
         if (axi_bvalid_o && axi_bready_i) begin
            resp = axi_bresp_o;
            done = 1'b1;
         end
         @(posedge clk); #1;
         if (done) break;
      end
      axi_bready_i = 1'b0;
      chk("b_handshake", done, 1);
      @(negedge clk);
      chk("w_readies_gap", {axi_awready_o, axi_wready_o}, 2'b00);
      @(posedge clk); #1;
      @(negedge clk);
      chk("w_readies_back", {axi_awready_o, axi_wready_o}, 2'b11);
      @(posedge clk); #1;
   endtask

   task automatic do_read(input logic [31:0] a, input int ar_dly, input int r_dly,
                          output logic [31:0] data, output logic [1:0] resp);
      bit pend = 1'b1;
      bit done = 1'b0;
      data = 32'hx;
      resp = 2'bxx;
      axi_araddr_i = a;
      for (int c = 0; c < 40 && pend; c++) begin
         axi_arvalid_i = (c >= ar_dly);
         @(negedge clk);
         if (axi_arvalid_i && axi_arready_o) begin
            pend = 1'b0;
            model_read(a);
         end
         @(posedge clk); #1;
      end
      axi_arvalid_i = 1'b0;
      chk("ar_handshake", pend, 0);
      if (pend) return;
      for (int c = 0; c < 40; c++) begin
         axi_rready_i = (c >= r_dly);
         @(negedge clk);
         if (c == 0) chk("r_latency", axi_rvalid_o, 1);
         if (axi_rvalid_o && axi_rready_i) begin
            data = axi_rdata_o;
            resp = axi_rresp_o;
            done = 1'b1;
         end
         @(posedge clk); #1;
         if (done) break;
      end
      axi_rready_i = 1'b0;
      chk("r_handshake", done, 1);
      @(negedge clk);
      chk("arready_back", axi_arready_o, 1);
      @(posedge clk); #1;
   endtask

   task automatic reset_cycles(input int n);
      rst_i = 1'b0;
      repeat (n) @(posedge clk);
      #1 rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [1:0]  resp, rresp;
      logic [31:0] rd, a, d;
      int          r;

      for (int i = 0; i < DEPTH; i++) mdl_known[i] = 4'h0;
      rst_i = 1'b0;
      axi_awvalid_i = 1'b0; axi_awaddr_i = 32'h0; axi_wvalid_i = 1'b0; axi_wdata_i = 32'h0;
      axi_wstrb_i = 4'h0; axi_bready_i = 1'b0; axi_arvalid_i = 1'b0; axi_araddr_i = 32'h0;
      axi_rready_i = 1'b0;

      // Reset: three cycles low, readies rise at the first edge after release
      repeat (3) @(posedge clk);
      #1 rst_i = 1'b1;
      @(negedge clk);
      chk("pre_edge_readies", {axi_awready_o, axi_wready_o, axi_arready_o}, 3'b000);
      @(posedge clk); #1;
      @(negedge clk);
      chk("post_edge_readies", {axi_awready_o, axi_wready_o, axi_arready_o}, 3'b111);
      @(posedge clk); #1;

      // Full write then read
      do_write(BASE + 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 1'b0, resp);
      chk("d_full_bresp", resp, 2'b00);
      do_read(BASE + 32'h10, 0, 0, rd, rresp);
      chk("d_full_rdata", rd, 32'hDEAD_BEEF);
      chk("d_full_rresp", rresp, 2'b00);

      // W three cycles ahead of AW, sparse strobes
      do_write(BASE + 32'h10, 32'h1122_3344, 4'b0101, 3, 0, 0, 1'b0, resp);
      do_read(BASE + 32'h10, 0, 0, rd, rresp);
      chk("d_strb_rdata", rd, 32'hDE22_BE44);

      // Backpressure on both response channels
      do_write(BASE + 32'h14, 32'h600D_CAFE, 4'hF, 1, 2, 5, 1'b0, resp);
      chk("d_bp_bresp", resp, 2'b00);
      do_read(BASE + 32'h14, 1, 5, rd, rresp);
      chk("d_bp_rdata", rd, 32'h600D_CAFE);

      // Out-of-range access one span above the base
      do_write(BASE, 32'h0102_0304, 4'hF, 0, 0, 0, 1'b0, resp);
      do_write(BASE + 32'h400, 32'hCAFE_F00D, 4'hF, 0, 0, 0, 1'b0, resp);
      do_read(BASE + 32'h400, 0, 0, rd, rresp);
`ifdef AXI_LITE_MEM_S_SLVERR_EN
      chk("d_oor_bresp", resp, 2'b10);
      chk("d_oor_rresp", rresp, 2'b10);
      chk("d_oor_rdata", rd, 32'h0);
      do_read(BASE, 0, 0, rd, rresp);
      chk("d_oor_word0", rd, 32'h0102_0304);
`else
      chk("d_alias_bresp", resp, 2'b00);
      chk("d_alias_rresp", rresp, 2'b00);
      chk("d_alias_rdata", rd, 32'hCAFE_F00D);
      do_read(BASE, 0, 0, rd, rresp);
      chk("d_alias_word0", rd, 32'hCAFE_F00D);
`endif

      // Collision: write commit and read sample on the same edge at the same index
      do_write(BASE + 32'h30, 32'h0BAD_F00D, 4'hF, 0, 0, 0, 1'b0, resp);
      axi_awaddr_i = BASE + 32'h30; axi_wdata_i = 32'h1234_5678; axi_wstrb_i = 4'hF;
      axi_araddr_i = BASE + 32'h30;
      axi_awvalid_i = 1'b1; axi_wvalid_i = 1'b1; axi_arvalid_i = 1'b1;
      @(negedge clk);
      chk("coll_readies", {axi_awready_o, axi_wready_o, axi_arready_o}, 3'b111);
      model_read(BASE + 32'h30);
      model_write(BASE + 32'h30, 32'h1234_5678, 4'hF);
      @(posedge clk); #1;
      axi_awvalid_i = 1'b0; axi_wvalid_i = 1'b0; axi_arvalid_i = 1'b0;
      axi_bready_i = 1'b1; axi_rready_i = 1'b1;
      @(negedge clk);
      chk("coll_valids", {axi_bvalid_o, axi_rvalid_o}, 2'b11);
      chk("coll_old_data", axi_rdata_o, 32'h0BAD_F00D);
      @(posedge clk); #1;
      axi_bready_i = 1'b0; axi_rready_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_read(BASE + 32'h30, 0, 0, rd, rresp);
      chk("coll_new_data", rd, 32'h1234_5678);

      // Reset while bvalid is held; the word is left unchecked afterwards
      do_write(BASE + 32'h40, 32'h7777_0000, 4'hF, 0, 0, 10, 1'b1, resp);
      mdl_known[idx_of(BASE + 32'h40)] = 4'h0;
      repeat (2) @(posedge clk);
      #1 rst_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      // AW latched alone, then reset: the pending write must be discarded
      do_write(BASE + 32'h20, 32'hA5A5_5A5A, 4'hF, 0, 0, 0, 1'b0, resp);
      axi_awaddr_i = BASE + 32'h20; axi_awvalid_i = 1'b1;
      @(negedge clk);
      chk("aw_only_ready", axi_awready_o, 1);
      @(posedge clk); #1;
      axi_awvalid_i = 1'b0;
      @(negedge clk);
      chk("aw_only_state", {axi_awready_o, axi_wready_o}, 2'b01);
      #2;
      reset_cycles(2);
      do_write(BASE + 32'h24, 32'h5555_AAAA, 4'hF, 2, 0, 0, 1'b0, resp);
      do_read(BASE + 32'h20, 0, 0, rd, rresp);
      chk("discard_rdata", rd, 32'hA5A5_5A5A);
      do_read(BASE + 32'h24, 0, 0, rd, rresp);
      chk("discard_other", rd, 32'h5555_AAAA);

      // Randomized traffic scored by the compare process
      for (int n = 0; n < 60; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0) a = BASE + 32'h400 + 32'($urandom_range(0, 255)) * 32'd4;
         else if (r == 1) a = BASE - 32'($urandom_range(1, 4)) * 32'd4;
         else a = BASE + 32'($urandom_range(0, 255)) * 32'd4 + 32'($urandom_range(0, 3));
         if (n < 8) a = BASE + 32'h80 + 32'(n) * 32'd4;
         d = $urandom;
         if ($urandom_range(0, 1) == 0 || n < 8) begin
            do_write(a, d, (n < 8) ? 4'hF : 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                     $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, resp);
         end else begin
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), rd, rresp);
         end
      end
      for (int n = 0; n < 8; n++) begin
         do_read(BASE + 32'h80 + 32'(n) * 32'd4, 0, $urandom_range(0, 2), rd, rresp);
      end

      repeat (3) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
